// File: rtl/hazard_sched.sv
// Pipeline stall/flush sequencer for the 5-stage RV32I core, with a small wait-tracking FSM
// and stall/redirect performance counters.
module hazard_sched #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned OP_WIDTH       = 7,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [OP_WIDTH-1:0]       Op_D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1_D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2_D,
  input  logic [REG_ADDR_WIDTH-1:0] Rd_E,
  input  logic                      RegWrite_E,
  input  logic                      MemRead_E,
  input  logic                      PCSrc_E,
  input  logic                      imem_ready,
  input  logic                      dmem_ready,
  input  logic                      MemAcc_M,
  output logic                      Stall_F,
  output logic                      Stall_D,
  output logic                      Flush_D,
  output logic                      Flush_E,
  output logic                      Stall_EMW,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      flush_events
);

  localparam logic [OP_WIDTH-1:0] OpImm    = 7'b0010011;
  localparam logic [OP_WIDTH-1:0] OpLoad   = 7'b0000011;
  localparam logic [OP_WIDTH-1:0] OpStore  = 7'b0100011;
  localparam logic [OP_WIDTH-1:0] OpBranch = 7'b1100011;
  localparam logic [OP_WIDTH-1:0] OpJalr   = 7'b1100111;
  localparam logic [OP_WIDTH-1:0] OpReg    = 7'b0110011;

  typedef enum logic [1:0] {StRun, StDmemWait, StRedirWait} state_e;

  state_e state_q, state_d;
  logic   use1, use2, load_use, dmem_busy, redirect;

  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    unique case (Op_D)
      OpImm, OpLoad, OpJalr:   use1 = 1'b1;
      OpStore, OpBranch, OpReg: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign load_use = MemRead_E & RegWrite_E & (Rd_E != '0) &
                    ((use1 & (Rs1_D == Rd_E)) | (use2 & (Rs2_D == Rd_E)));
  assign dmem_busy = MemAcc_M & ~dmem_ready;

  always_comb begin
    Stall_F   = 1'b0;
    Stall_D   = 1'b0;
    Flush_D   = 1'b0;
    Flush_E   = 1'b0;
    Stall_EMW = 1'b0;
    redirect  = 1'b0;
    state_d   = state_q;
    if (!rst_n) begin
      state_d = StRun;
    end else if (dmem_busy) begin
      // E is frozen, so a pending redirect stays presented and is taken after release.
      Stall_F   = 1'b1;
      Stall_D   = 1'b1;
      Stall_EMW = 1'b1;
      if (state_q == StRun) state_d = StDmemWait;
    end else begin
      if (state_q == StDmemWait) state_d = StRun;
      if (PCSrc_E) begin
        Flush_D  = 1'b1;
        Flush_E  = 1'b1;
        redirect = 1'b1;
        state_d  = imem_ready ? StRun : StRedirWait;
      end else if (state_q == StRedirWait) begin
        Flush_D = 1'b1;
        if (imem_ready) state_d = StRun;
      end else if (load_use) begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Flush_E = 1'b1;
      end else if (!imem_ready) begin
        Stall_F = 1'b1;
        Flush_D = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (Stall_F)  stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      if (redirect) flush_events <= flush_events + CNT_WIDTH'(1);
    end
  end

endmodule
